// File: rtl/scalar_reorder_buffer_pkg.sv
// Shared types for the scalar reorder buffer: register index, data, hazard slot
// and the per-entry record held in the buffer.
package scalar_reorder_buffer_pkg;

    localparam int unsigned NUM_ENTRY_RB_S = 16;
    localparam int unsigned WIDTH_TAG_RB_S = $clog2(NUM_ENTRY_RB_S);
    localparam int unsigned WIDTH_INDEX    = 5;
    localparam int unsigned WIDTH_DATA     = 32;
    localparam int unsigned WIDTH_ISSUE_NO = 4;

    typedef logic [WIDTH_INDEX-1:0]    index_t;
    typedef logic [WIDTH_DATA-1:0]     data_t;
    typedef logic [WIDTH_ISSUE_NO-1:0] issue_no_t;
    typedef logic [WIDTH_TAG_RB_S-1:0] rob_tag_t;

    typedef struct packed {
        logic      v;
        logic      done;
        logic      we;
        index_t    dst;
        issue_no_t no;
        data_t     data;
    } rob_entry_t;

endpackage

// File: rtl/scalar_reorder_buffer_ptr_ctrl.sv
// Head/tail/count bookkeeping for the reorder buffer, with full/empty flags.
module rob_ptr_ctrl #(
    parameter int unsigned NUM_ENTRY = 16,
    parameter int unsigned WIDTH_TAG = $clog2(NUM_ENTRY)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 issue,
    input  logic                 commit,
    output logic [WIDTH_TAG-1:0] head,
    output logic [WIDTH_TAG-1:0] tail,
    output logic                 full,
    output logic                 empty
);

    logic [WIDTH_TAG:0] count;

    assign full  = (count == (WIDTH_TAG+1)'(NUM_ENTRY));
    assign empty = (count == '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head <= head + WIDTH_TAG'(commit);
            tail <= tail + WIDTH_TAG'(issue);
            // Simultaneous issue and commit cancel out.
            case ({issue, commit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/scalar_reorder_buffer.sv
// In-order commit buffer: allocates tags at issue, accepts out-of-order
// writebacks by tag, and retires completed entries strictly in issue order.
module scalar_reorder_buffer
    import scalar_reorder_buffer_pkg::*;
#(
    parameter int unsigned NUM_ENTRY = NUM_ENTRY_RB_S,
    parameter int unsigned WIDTH_TAG = $clog2(NUM_ENTRY)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 I_Issue,
    input  logic                 I_Issue_We,
    input  index_t               I_Issue_Dst,
    input  issue_no_t            I_Issue_No,
    output logic [WIDTH_TAG-1:0] O_Issue_Tag,
    output logic                 O_Full,
    output logic                 O_Empty,
    input  logic                 I_WB,
    input  logic [WIDTH_TAG-1:0] I_WB_Tag,
    input  data_t                I_WB_Data,
    output logic                 O_Commit,
    output logic                 O_Commit_We,
    output index_t               O_Commit_Dst,
    output data_t                O_Commit_Data,
    output issue_no_t            O_Commit_No,
    input  logic                 I_Flush,
    output logic                 O_Err
);

    rob_entry_t           entries [NUM_ENTRY];
    rob_entry_t           head_entry;
    rob_entry_t           wb_entry;
    logic [WIDTH_TAG-1:0] head;
    logic [WIDTH_TAG-1:0] tail;
    logic                 issue_ok;
    logic                 wb_ok;
    logic                 err_set;

    rob_ptr_ctrl #(
        .NUM_ENTRY (NUM_ENTRY),
        .WIDTH_TAG (WIDTH_TAG)
    ) u_ptr (
        .clock  (clock),
        .reset  (reset),
        .flush  (I_Flush),
        .issue  (issue_ok),
        .commit (O_Commit),
        .head   (head),
        .tail   (tail),
        .full   (O_Full),
        .empty  (O_Empty)
    );

    assign head_entry = entries[head];
    assign wb_entry   = entries[I_WB_Tag];

    assign issue_ok = I_Issue & ~O_Full & ~I_Flush;
    assign wb_ok    = I_WB & wb_entry.v & ~wb_entry.done & ~I_Flush;
    // Flush overrides issue and writeback, so neither can raise an error then.
    assign err_set  = ~I_Flush & ((I_Issue & O_Full) |
                                  (I_WB & ~(wb_entry.v & ~wb_entry.done)));

    assign O_Issue_Tag   = tail;
    assign O_Commit      = head_entry.v & head_entry.done & ~I_Flush;
    assign O_Commit_We   = O_Commit & head_entry.we;
    assign O_Commit_Dst  = head_entry.dst;
    assign O_Commit_Data = head_entry.data;
    assign O_Commit_No   = head_entry.no;

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
                entries[i] <= '0;
            end
            O_Err <= 1'b0;
        end else begin
            if (I_Flush) begin
                for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
                    entries[i].v <= 1'b0;
                end
            end else begin
                // Issue, writeback and commit never target the same slot:
                // the tail slot is invalid and the head slot is already done.
                if (issue_ok) begin
                    entries[tail] <= '{v: 1'b1, done: 1'b0, we: I_Issue_We,
                                       dst: I_Issue_Dst, no: I_Issue_No,
                                       data: '0};
                end
                if (wb_ok) begin
                    entries[I_WB_Tag].done <= 1'b1;
                    entries[I_WB_Tag].data <= I_WB_Data;
                end
                if (O_Commit) begin
                    entries[head].v <= 1'b0;
                end
            end
            if (err_set) begin
                O_Err <= 1'b1;
            end
        end
    end

endmodule
